// File: rtl/gpio_pattern_sequencer.sv
// Pattern sequencer: a Wishbone slave register file plus a Wishbone master
// that writes up to eight stored patterns into the GPIO OUT register.
`timescale 1ns/1ps
module gpio_pattern_sequencer #(
    parameter logic [16:0] MODULE_OFFSET     = 17'h0_2000,
    parameter logic [31:0] DEFAULT_REG_VALUE = 32'hFAB_DEF_AC,
    parameter logic [16:0] GPIO_OUT_ADDR     = 17'h0_1004,
    parameter int unsigned ACK_TIMEOUT       = 16
) (
    input  logic        WBs_CLK_i,
    input  logic        WBs_RST_i,
    input  logic [16:0] WBs_ADR_i,
    input  logic        WBs_CYC_i,
    input  logic [3:0]  WBs_BYTE_STB_i,
    input  logic        WBs_WE_i,
    input  logic        WBs_STB_i,
    input  logic [31:0] WBs_DAT_i,
    output logic [31:0] WBs_DAT_o,
    output logic        WBs_ACK_o,
    output logic [16:0] WBm_ADR_o,
    output logic        WBm_CYC_o,
    output logic        WBm_STB_o,
    output logic        WBm_WE_o,
    output logic [3:0]  WBm_BYTE_STB_o,
    output logic [31:0] WBm_DAT_o,
    input  logic        WBm_ACK_i,
    output logic        Seq_Done_o
);

    localparam int unsigned NUM_PAT = 8;
    localparam int unsigned TMO_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic               loop_q, loop_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [31:0]        interval_q, interval_d;
    logic [3:0]         length_q, length_d;
    logic [31:0]        pattern_q [NUM_PAT];
    logic [31:0]        pattern_d [NUM_PAT];
    logic [2:0]         idx_q, idx_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               cyc_q, cyc_d;
    logic [31:0]        dat_q, dat_d;
    logic               seq_done_q, seq_done_d;
    logic               ack_q, ack_d;

    logic               slv_req_c;
    logic               slv_wr_c;
    logic [5:0]         reg_off_c;
    logic [3:0]         len_eff_c;
    logic               start_write_c;
    logic               fsm_clr_en_c;
    logic               fsm_set_done_c;
    logic               fsm_set_err_c;
    logic [31:0]        rd_data_c;
    logic               unused_adr_c;

    assign unused_adr_c = ^WBs_ADR_i[1:0];

    // Byte-strobe merge of slave write data into an existing register value
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    // Slave decode; a request is acked exactly once, one cycle after it is seen
    always_comb begin
        slv_req_c = (WBs_ADR_i[16:8] == MODULE_OFFSET[16:8]) && WBs_CYC_i && WBs_STB_i && !ack_q;
        slv_wr_c  = slv_req_c && WBs_WE_i;
        reg_off_c = WBs_ADR_i[7:2];
        ack_d     = slv_req_c;
        len_eff_c = (length_q > 4'd8) ? 4'd8 : length_q;
    end

    // Sequencer next-state, master bus and done-pulse logic
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        cyc_d          = cyc_q;
        dat_d          = dat_q;
        seq_done_d     = 1'b0;
        start_write_c  = 1'b0;
        fsm_clr_en_c   = 1'b0;
        fsm_set_done_c = 1'b0;
        fsm_set_err_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_q && (len_eff_c != 4'd0)) begin
                    idx_d         = 3'd0;
                    start_write_c = 1'b1;
                end
            end
            ST_WRITE: begin
                if (WBm_ACK_i) begin
                    cyc_d = 1'b0;
                    if (en_q) begin
                        cnt_d   = interval_q;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d         = 1'b0;
                    fsm_set_err_c = 1'b1;
                    fsm_clr_en_c  = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WAIT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if ((4'({1'b0, idx_q}) + 4'd1) < len_eff_c) begin
                    idx_d         = idx_q + 3'd1;
                    start_write_c = 1'b1;
                end else if (loop_q && (len_eff_c != 4'd0)) begin
                    idx_d         = 3'd0;
                    start_write_c = 1'b1;
                end else begin
                    fsm_set_done_c = 1'b1;
                    fsm_clr_en_c   = 1'b1;
                    seq_done_d     = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
        if (start_write_c) begin
            state_d = ST_WRITE;
            cyc_d   = 1'b1;
            tmo_d   = '0;
            dat_d   = pattern_q[idx_d];
        end
    end

    // Register file updates; a slave write lands after FSM updates so it wins
    always_comb begin
        en_d       = en_q;
        loop_d     = loop_q;
        done_d     = done_q;
        err_d      = err_q;
        interval_d = interval_q;
        length_d   = length_q;
        pattern_d  = pattern_q;
        if (fsm_clr_en_c)   en_d   = 1'b0;
        if (fsm_set_done_c) done_d = 1'b1;
        if (fsm_set_err_c)  err_d  = 1'b1;
        if (slv_wr_c) begin
            case (reg_off_c)
                6'h00: begin
                    if (WBs_BYTE_STB_i[0]) begin
                        en_d   = WBs_DAT_i[0];
                        loop_d = WBs_DAT_i[1];
                        if (WBs_DAT_i[0]) begin
                            done_d = 1'b0;
                            err_d  = 1'b0;
                        end
                    end
                end
                6'h02: interval_d = merge_bytes(interval_q, WBs_DAT_i, WBs_BYTE_STB_i);
                6'h03: if (WBs_BYTE_STB_i[0]) length_d = WBs_DAT_i[3:0];
                default: begin
                    if (reg_off_c[5:3] == 3'b001) begin
                        pattern_d[reg_off_c[2:0]] =
                            merge_bytes(pattern_q[reg_off_c[2:0]], WBs_DAT_i, WBs_BYTE_STB_i);
                    end
                end
            endcase
        end
    end

    // Slave read mux
    always_comb begin
        rd_data_c = DEFAULT_REG_VALUE;
        case (reg_off_c)
            6'h00: rd_data_c = {30'd0, loop_q, en_q};
            6'h01: rd_data_c = {21'd0, idx_q, 5'd0, err_q, done_q, (state_q != ST_IDLE)};
            6'h02: rd_data_c = interval_q;
            6'h03: rd_data_c = {28'd0, length_q};
            default: begin
                if (reg_off_c[5:3] == 3'b001) rd_data_c = pattern_q[reg_off_c[2:0]];
            end
        endcase
    end

    // State and register flops
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            loop_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            interval_q <= '0;
            length_q   <= '0;
            for (int i = 0; i < NUM_PAT; i++) pattern_q[i] <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            cyc_q      <= 1'b0;
            dat_q      <= '0;
            seq_done_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            loop_q     <= loop_d;
            done_q     <= done_d;
            err_q      <= err_d;
            interval_q <= interval_d;
            length_q   <= length_d;
            pattern_q  <= pattern_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            cyc_q      <= cyc_d;
            dat_q      <= dat_d;
            seq_done_q <= seq_done_d;
            ack_q      <= ack_d;
        end
    end

    assign WBs_DAT_o      = rd_data_c;
    assign WBs_ACK_o      = ack_q;
    assign WBm_CYC_o      = cyc_q;
    assign WBm_STB_o      = cyc_q;
    assign WBm_WE_o       = cyc_q;
    assign WBm_BYTE_STB_o = {4{cyc_q}};
    assign WBm_ADR_o      = cyc_q ? GPIO_OUT_ADDR : 17'd0;
    assign WBm_DAT_o      = dat_q;
    assign Seq_Done_o     = seq_done_q;

endmodule

// File: tb/tb_gpio_pattern_sequencer.sv
// Directed bench for gpio_pattern_sequencer with a delayed-ACK GPIO responder.
`timescale 1ns/1ps
module tb_gpio_pattern_sequencer;

    localparam logic [16:0] A_CTRL   = 17'h0_2000;
    localparam logic [16:0] A_STATUS = 17'h0_2004;
    localparam logic [16:0] A_INTV   = 17'h0_2008;
    localparam logic [16:0] A_LEN    = 17'h0_200C;
    localparam logic [16:0] A_PAT0   = 17'h0_2020;

    logic        clk, rst;
    logic [16:0] s_adr;
    logic        s_cyc, s_we, s_stb;
    logic [3:0]  s_be;
    logic [31:0] s_wdat, s_rdat;
    logic        s_ack;
    logic [16:0] m_adr;
    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_dat;
    logic        m_ack;
    logic        seq_done;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_pattern_sequencer dut (
        .WBs_CLK_i(clk), .WBs_RST_i(rst), .WBs_ADR_i(s_adr), .WBs_CYC_i(s_cyc),
        .WBs_BYTE_STB_i(s_be), .WBs_WE_i(s_we), .WBs_STB_i(s_stb), .WBs_DAT_i(s_wdat),
        .WBs_DAT_o(s_rdat), .WBs_ACK_o(s_ack), .WBm_ADR_o(m_adr), .WBm_CYC_o(m_cyc),
        .WBm_STB_o(m_stb), .WBm_WE_o(m_we), .WBm_BYTE_STB_o(m_be), .WBm_DAT_o(m_dat),
        .WBm_ACK_i(m_ack), .Seq_Done_o(seq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GPIO responder: ACK in cycle (ack_delay+1) of each master cycle
    int ack_delay = 1;
    bit ack_never = 1'b0;
    int age = 0;
    always @(negedge clk) begin
        if (m_cyc) age++;
        else age = 0;
        m_ack = m_cyc && !ack_never && (age == ack_delay + 1);
    end

    // Master bus monitor
    longint      rise_t[$];
    longint      fall_t[$];
    logic [31:0] rise_dat[$];
    int          bad_attr = 0;
    int          bad_dat = 0;
    int          done_pulses = 0;
    logic        cyc_prev = 1'b0;
    always @(negedge clk) begin
        if (m_cyc && !cyc_prev) begin
            rise_t.push_back($time);
            rise_dat.push_back(m_dat);
        end
        if (!m_cyc && cyc_prev) fall_t.push_back($time);
        if (m_cyc) begin
            if (!m_stb || !m_we || m_be != 4'hF || m_adr != 17'h0_1004) bad_attr++;
            if (rise_dat.size() > 0 && m_dat !== rise_dat[$]) bad_dat++;
        end
        if (seq_done) done_pulses++;
        cyc_prev = m_cyc;
    end

    task automatic clear_mon();
        rise_t.delete();
        fall_t.delete();
        rise_dat.delete();
        bad_attr = 0;
        bad_dat = 0;
        done_pulses = 0;
    endtask

    task automatic wb_access(input logic [16:0] a, input logic we, input logic [31:0] d,
                             input logic [3:0] be, output logic [31:0] rd);
        bit ok;
        ok = 1'b0;
        rd = 32'hxxxx_xxxx;
        @(posedge clk); #1;
        s_adr = a; s_we = we; s_wdat = d; s_be = be; s_cyc = 1'b1; s_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (s_ack) begin
                ok = 1'b1;
                rd = s_rdat;
                break;
            end
        end
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wb_ack addr=%h: no slave ACK within 4 cycles", a);
        end
    endtask

    task automatic wb_write(input logic [16:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(a, 1'b1, d, 4'hF, dummy);
    endtask

    task automatic wb_read(input logic [16:0] a, output logic [31:0] rd);
        wb_access(a, 1'b0, 32'd0, 4'hF, rd);
    endtask

    task automatic wait_rises(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rise_t.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_falls(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fall_t.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [16:0] addrs [5];
        addrs = '{A_CTRL, A_STATUS, A_INTV, A_LEN, A_PAT0};
        rst = 1'b1;
        s_adr = A_CTRL; s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; s_be = 4'h0; s_wdat = 32'd0;
        m_ack = 1'b0;
        #23;
        n_tests++;
        if ({s_ack, m_cyc, m_stb, m_we, seq_done} !== 5'b0 || m_dat !== 32'd0 ||
            m_be !== 4'd0 || m_adr !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack/cyc/stb/we/done=%b dat=%h be=%h adr=%h, required all 0",
                     {s_ack, m_cyc, m_stb, m_we, seq_done}, m_dat, m_be, m_adr);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb_read(addrs[i], rd);
            n_tests++;
            if (rd !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_reg addr=%h: got %h, required 00000000", addrs[i], rd);
            end
        end
    endtask

    task automatic test_slave();
        logic [31:0] rd;
        @(posedge clk); #1;
        s_adr = A_PAT0 + 17'h0C; s_we = 1'b1; s_wdat = 32'h1234_5678; s_be = 4'b0010;
        s_cyc = 1'b1; s_stb = 1'b1;
        n_tests++;
        if (s_ack !== 1'b0) begin
            n_fail++; $display("FAIL slave_ack_early: got %b, required 0", s_ack);
        end
        @(posedge clk); #1;
        n_tests++;
        if (s_ack !== 1'b1) begin
            n_fail++; $display("FAIL slave_ack_high: got %b, required 1", s_ack);
        end
        @(posedge clk); #1;
        n_tests++;
        if (s_ack !== 1'b0) begin
            n_fail++; $display("FAIL slave_ack_one_cycle: got %b, required 0", s_ack);
        end
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        wb_read(A_PAT0 + 17'h0C, rd);
        n_tests++;
        if (rd !== 32'h0000_5600) begin
            n_fail++; $display("FAIL byte_strobe_pat3: got %h, required 00005600", rd);
        end
        wb_read(17'h0_2040, rd);
        n_tests++;
        if (rd !== 32'hFABD_EFAC) begin
            n_fail++; $display("FAIL unimpl_read: got %h, required fabdefac", rd);
        end
        wb_access(A_INTV, 1'b1, 32'hAABB_CCDD, 4'b1001, rd);
        wb_read(A_INTV, rd);
        n_tests++;
        if (rd !== 32'hAA00_00DD) begin
            n_fail++; $display("FAIL byte_strobe_intv: got %h, required aa0000dd", rd);
        end
        // Access outside the module window must not be acknowledged
        @(posedge clk); #1;
        s_adr = 17'h0_1000; s_we = 1'b0; s_be = 4'hF; s_cyc = 1'b1; s_stb = 1'b1;
        rd[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (s_ack) rd[0] = 1'b1;
        end
        s_cyc = 1'b0; s_stb = 1'b0;
        n_tests++;
        if (rd[0] !== 1'b0) begin
            n_fail++; $display("FAIL decode_miss: ack seen=%b, required 0", rd[0]);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] rd, got;
        logic [31:0] exp_d [3];
        bit ok;
        exp_d = '{32'hA5, 32'h5A, 32'hFF};
        wb_write(A_PAT0,          32'hA5);
        wb_write(A_PAT0 + 17'h4,  32'h5A);
        wb_write(A_PAT0 + 17'h8,  32'hFF);
        wb_write(A_LEN, 32'd3);
        wb_write(A_INTV, 32'd4);
        ack_delay = 1;
        clear_mon();
        wb_write(A_CTRL, 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_pulses > 0) begin ok = 1'b1; break; end
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if (!ok || done_pulses != 1) begin
            n_fail++; $display("FAIL oneshot_done_pulses: got %0d, required 1", done_pulses);
        end
        n_tests++;
        if (rise_t.size() != 3) begin
            n_fail++; $display("FAIL oneshot_writes: got %0d, required 3", rise_t.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < rise_dat.size()) ? rise_dat[i] : 32'hxxxx_xxxx;
            n_tests++;
            if (got !== exp_d[i]) begin
                n_fail++; $display("FAIL oneshot_data[%0d]: got %h, required %h", i, got, exp_d[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (rise_t.size() < 3 || rise_t[i+1] - rise_t[i] != 70) begin
                n_fail++;
                $display("FAIL oneshot_spacing[%0d]: got %0d ns, required 70 ns", i,
                         (rise_t.size() < 3) ? -1 : rise_t[i+1] - rise_t[i]);
            end
        end
        n_tests++;
        if (bad_attr != 0 || bad_dat != 0) begin
            n_fail++; $display("FAIL oneshot_bus_attr: bad_attr=%0d bad_dat=%0d, required 0/0",
                               bad_attr, bad_dat);
        end
        wb_read(A_STATUS, rd);
        n_tests++;
        if (rd !== 32'h0000_0202) begin
            n_fail++; $display("FAIL oneshot_status: got %h, required 00000202", rd);
        end
        wb_read(A_CTRL, rd);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL oneshot_ctrl: got %h, required 00000000", rd);
        end
    endtask

    task automatic test_loop();
        logic [31:0] rd, got, exp;
        bit ok;
        int nf, nr;
        wb_write(A_PAT0,         32'h11);
        wb_write(A_PAT0 + 17'h4, 32'h22);
        wb_write(A_LEN, 32'd2);
        wb_write(A_INTV, 32'd0);
        ack_delay = 1;
        clear_mon();
        wb_write(A_CTRL, 32'h3);
        wait_rises(5, 100, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL loop_progress: got %0d writes, required >=5", rise_t.size());
        end
        for (int i = 0; i < 5; i++) begin
            got = (i < rise_dat.size()) ? rise_dat[i] : 32'hxxxx_xxxx;
            exp = (i % 2 == 0) ? 32'h11 : 32'h22;
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL loop_data[%0d]: got %h, required %h", i, got, exp);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rise_t.size() < 5 || rise_t[i+1] - rise_t[i] != 30) begin
                n_fail++;
                $display("FAIL loop_spacing[%0d]: got %0d ns, required 30 ns", i,
                         (rise_t.size() < 5) ? -1 : rise_t[i+1] - rise_t[i]);
            end
        end
        // Stretch the wait so the disable lands inside it
        wb_write(A_INTV, 32'd20);
        nf = fall_t.size();
        wait_falls(nf + 2, 60, ok);
        wb_write(A_CTRL, 32'h2);
        nr = rise_t.size();
        repeat (40) @(negedge clk);
        n_tests++;
        if (!ok || rise_t.size() != nr) begin
            n_fail++; $display("FAIL loop_stop: writes after disable=%0d, required 0 (wait ok=%0d)",
                               rise_t.size() - nr, ok);
        end
        wb_read(A_STATUS, rd);
        exp = 32'(((nr - 1) % 2) << 8);
        n_tests++;
        if (rd !== exp) begin
            n_fail++; $display("FAIL loop_status: got %h, required %h", rd, exp);
        end
        n_tests++;
        if (done_pulses != 0) begin
            n_fail++; $display("FAIL loop_no_done: got %0d pulses, required 0", done_pulses);
        end
        wb_read(A_CTRL, rd);
        n_tests++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL loop_ctrl: got %h, required 00000002", rd);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        bit ok;
        wb_write(A_INTV, 32'd0);
        wb_write(A_LEN, 32'd1);
        ack_never = 1'b1;
        clear_mon();
        wb_write(A_CTRL, 32'h1);
        wait_falls(1, 60, ok);
        repeat (5) @(negedge clk);
        ack_never = 1'b0;
        n_tests++;
        if (!ok || rise_t.size() != 1 || fall_t[0] - rise_t[0] != 160) begin
            n_fail++;
            $display("FAIL timeout_cyc_len: got %0d ns (writes=%0d), required 160 ns",
                     (ok && rise_t.size() > 0) ? fall_t[0] - rise_t[0] : -1, rise_t.size());
        end
        wb_read(A_STATUS, rd);
        n_tests++;
        if (rd !== 32'h0000_0004) begin
            n_fail++; $display("FAIL timeout_status: got %h, required 00000004", rd);
        end
        wb_read(A_CTRL, rd);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL timeout_ctrl: got %h, required 00000000", rd);
        end
        n_tests++;
        if (done_pulses != 0) begin
            n_fail++; $display("FAIL timeout_no_done: got %0d pulses, required 0", done_pulses);
        end
    endtask

    task automatic test_mid_write_disable();
        logic [31:0] rd, got;
        bit ok1, ok2;
        wb_write(A_LEN, 32'd2);
        ack_delay = 5;
        clear_mon();
        wb_write(A_CTRL, 32'h1);
        wait_rises(1, 20, ok1);
        wb_write(A_CTRL, 32'h0);
        wait_falls(1, 40, ok2);
        repeat (20) @(negedge clk);
        ack_delay = 1;
        n_tests++;
        if (!ok1 || !ok2 || rise_t.size() != 1 || fall_t[0] - rise_t[0] != 60) begin
            n_fail++;
            $display("FAIL middis_cyc_len: got %0d ns (writes=%0d), required 60 ns, 1 write",
                     (ok1 && ok2) ? fall_t[0] - rise_t[0] : -1, rise_t.size());
        end
        got = (rise_dat.size() > 0) ? rise_dat[0] : 32'hxxxx_xxxx;
        n_tests++;
        if (got !== 32'h11 || bad_dat != 0) begin
            n_fail++; $display("FAIL middis_data: got %h (changes=%0d), required 00000011 stable",
                               got, bad_dat);
        end
        wb_read(A_STATUS, rd);
        n_tests++;
        if (rd !== 32'h0 || done_pulses != 0) begin
            n_fail++; $display("FAIL middis_status: got %h pulses=%0d, required 00000000 / 0",
                               rd, done_pulses);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        logic [16:0] addrs [4];
        bit ok;
        addrs = '{A_CTRL, A_STATUS, A_INTV, A_PAT0};
        wb_write(A_INTV, 32'd50);
        clear_mon();
        wb_write(A_CTRL, 32'h1);
        wait_falls(1, 30, ok);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (!ok || {s_ack, m_cyc, m_stb, m_we, seq_done} !== 5'b0 || m_dat !== 32'd0 ||
            m_be !== 4'd0 || m_adr !== 17'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: ack/cyc/stb/we/done=%b dat=%h, required all 0 (ok=%0d)",
                     {s_ack, m_cyc, m_stb, m_we, seq_done}, m_dat, ok);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_read(addrs[i], rd);
            n_tests++;
            if (rd !== 32'd0) begin
                n_fail++; $display("FAIL async_reset_reg addr=%h: got %h, required 00000000",
                                   addrs[i], rd);
            end
        end
        clear_mon();
        repeat (60) @(negedge clk);
        n_tests++;
        if (rise_t.size() != 0) begin
            n_fail++; $display("FAIL async_reset_idle: got %0d writes, required 0", rise_t.size());
        end
    endtask

    initial begin
        test_reset();
        test_slave();
        test_one_shot();
        test_loop();
        test_timeout();
        test_mid_write_disable();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpio_pattern_sequencer.md
Name: gpio_pattern_sequencer

Overview:
- Wishbone-slave-configured sequencer that plays a programmed list of up to 8 output patterns into the GPIO controller's OUT register.
- Issues one Wishbone master write per step, with a programmable interval between steps, in one-shot or loop mode.
- Sits on the FPGA fabric beside the GPIO controller. Its master port is muxed or hard-wired onto that controller's slave port.
- Same clock as the AHB-to-FPGA bridge.

Parameters:
- MODULE_OFFSET, 17'h0_2000, slave base address; decode compares WBs_ADR_i[16:8].
- DEFAULT_REG_VALUE, 32'hFAB_DEF_AC, read value for unimplemented offsets.
- GPIO_OUT_ADDR, 17'h0_1004, master write address (GPIO controller OUT register).
- ACK_TIMEOUT, 16, max cycles in WRITE waiting for WBm_ACK_i before abort.

Ports:
- WBs_CLK_i  in  1  clock for slave, master and sequencer.
- WBs_RST_i  in  1  reset.
- WBs_ADR_i  in  17  slave byte address.
- WBs_CYC_i  in  1  slave cycle.
- WBs_BYTE_STB_i  in  4  slave byte enables.
- WBs_WE_i  in  1  slave write enable.
- WBs_STB_i  in  1  slave strobe.
- WBs_DAT_i  in  32  slave write data.
- WBs_DAT_o  out  32  slave read data (combinational mux).
- WBs_ACK_o  out  1  slave acknowledge.
- WBm_ADR_o  out  17  master address.
- WBm_CYC_o  out  1  master cycle.
- WBm_STB_o  out  1  master strobe.
- WBm_WE_o  out  1  master write enable.
- WBm_BYTE_STB_o  out  4  master byte enables.
- WBm_DAT_o  out  32  master write data.
- WBm_ACK_i  in  1  master acknowledge.
- Seq_Done_o  out  1  one-cycle pulse when a one-shot run completes.

Behaviour:
- Clock/reset: single clock WBs_CLK_i. WBs_RST_i is asynchronous and active-high.
- Reset values: all registers 0; WBs_ACK_o=0; WBm_CYC/STB/WE=0; WBm_DAT_o=0; Seq_Done_o=0; FSM=IDLE.
- Slave protocol:
  - WBs_ACK_o <= decode & CYC & STB & ~WBs_ACK_o (exactly one cycle after request).
  - Writes occur in the same qualified cycle and honour byte strobes.
  - Reads mux on WBs_ADR_i[7:2].
- Register map (byte offsets):
  - 0x00 CTRL (RW): bit0 EN, bit1 LOOP.
  - 0x04 STATUS (RO): bit0 BUSY, bit1 DONE, bit2 ERR, bits[10:8] current index.
  - 0x08 INTERVAL (RW, 32b).
  - 0x0C LENGTH (RW, bits[3:0]); values >8 are treated as 8.
  - 0x20-0x3C PATTERN[0..7] (RW, 32b).
- Writing CTRL with EN=1 clears DONE and ERR.
- FSM states: IDLE, WRITE, WAIT.
- IDLE:
  - If EN=1 and LENGTH!=0: idx<=0, go WRITE.
  - If EN=1 and LENGTH=0: stay IDLE; EN remains set.
- WRITE:
  - Drive CYC=STB=WE=1, BYTE_STB=4'hF, ADR=GPIO_OUT_ADDR, DAT=PATTERN[idx] sampled on entry and held stable for the transaction.
  - Timeout counter starts at 0.
  - On WBm_ACK_i: CYC/STB drop the next cycle, cnt<=INTERVAL, go WAIT.
  - If the timeout counter reaches ACK_TIMEOUT without ACK: drop CYC/STB, set ERR, clear EN, go IDLE.
- WAIT:
  - If cnt==0, advance; otherwise cnt<=cnt-1.
  - For ACK at cycle t, the next CYC rises at t+1+INTERVAL (INTERVAL=0 gives one idle cycle between writes).
- Advance:
  - If idx < LEN-1: idx<=idx+1, go WRITE.
  - Else if LOOP: idx<=0, go WRITE.
  - Else: DONE<=1, EN<=0, Seq_Done_o pulses 1 cycle, go IDLE.
- Software clears EN mid-run:
  - In WRITE: the current transaction completes (never abandoned mid-cycle), then IDLE.
  - In WAIT: go IDLE next cycle.
  - DONE is not set and idx is held for readback in either case.
- Pattern or LENGTH writes while running take effect at the next WRITE entry. Shrinking LENGTH below idx+1 ends the pass at the next advance.
- A slave write to CTRL in the same cycle the FSM clears EN (done or timeout): the slave write wins.
- BUSY = (state != IDLE).

Test Plan:
- One-shot run: PATTERN0..2=0xA5,0x5A,0xFF; LENGTH=3; INTERVAL=4; CTRL=1; responder ACKs 1 cycle after STB -> three master writes to 0x1004 with data A5,5A,FF. CYC rise-to-rise spacing is 7 cycles. Seq_Done_o pulses once; STATUS=0x0000_0202 (DONE=1, index=2).
- Loop mode: LENGTH=2, LOOP=1, INTERVAL=0 -> data alternates P0,P1,P0,... with one idle cycle between writes. Clearing EN during WAIT -> no further CYC; DONE stays 0.
- Timeout: responder never ACKs, ACK_TIMEOUT=16 -> CYC held 16 cycles then drops. STATUS.ERR=1, EN reads 0, no Seq_Done_o.
- Mid-write disable: EN cleared while CYC high and responder delays ACK 5 cycles -> CYC stays high until ACK, then IDLE. Data unchanged throughout.
- Slave access: byte-strobe write 4'b0010 of 0x1234_5678 to PATTERN3 (0x2C) -> reads 0x0000_5600. Read of 0x40 returns 0xFABDEFAC. WBs_ACK_o is high exactly one cycle per access.
- Asynchronous reset asserted mid-WAIT -> all outputs 0 immediately, registers cleared, FSM IDLE after release.
